sc_div_sched: RTL

Round-robin scheduler that time-shares one stochastic counter-feedback divider among NREQ requesters. Each request carries binary dividend and divisor. The block then:
- converts both operands to bitstreams against external random numbers,
- runs the divider for a fixed stream length,
- counts quotient ones,
- returns a binary quotient with the requester ID.

It sits between the binary request fabric and the stochastic division datapath.

---
 rtl/sc_div_pkg.sv | 19 +
 rtl/sc_div_core.sv | 50 +++++
 rtl/sc_div_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sc_div_pkg.sv
// Shared types and helpers for the stochastic divider scheduler.
// The optional warm-up phase is controlled by the SC_DIV_WARMUP_EN macro.
package sc_div_pkg;

   localparam int DEFAULT_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARM,
      ST_RUN,
      ST_RESP
   } state_t;

   // Mid-scale start point for the feedback counter, i.e. a quotient guess of 0.5
   function automatic int cntInit(input int width);
      return 1 << (width - 1);
   endfunction

endpackage

// File: rtl/sc_div_core.sv
// Counter-feedback stochastic divider: a saturating up/down counter whose
// value, compared against a random number, produces the quotient bitstream.
module sc_div_core
   import sc_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             en_i,
   input  logic             inc_i,
   input  logic             bBit_i,
   input  logic [WIDTH-1:0] randQ_i,
   output logic             qBit_o
);

   localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(cntInit(WIDTH));

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             dec;

   assign qBit_o = (cnt_q > randQ_i);
   assign dec    = qBit_o & bBit_i;

   // Next counter value: reload on a new job, otherwise saturating step when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_INIT;
      end else if (en_i) begin
         if (inc_i && !dec && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end else if (!inc_i && dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Counter register, returns to mid-scale on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_INIT;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sc_div_sched.sv
// Round-robin scheduler sharing one stochastic divider among NREQ requesters.
// Define SC_DIV_WARMUP_EN to add a WARM-cycle settling phase before counting.
module sc_div_sched
   import sc_div_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int WARM  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_dividend,
   input  logic [NREQ*WIDTH-1:0]    req_divisor,
   input  logic [WIDTH-1:0]         rand_a,
   input  logic [WIDTH-1:0]         rand_b,
   input  logic [WIDTH-1:0]         rand_q,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]         rsp_quot,
   output logic                     rsp_err,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int LEN = 1 << WIDTH;
   localparam int PHW = (WIDTH > $clog2(WARM + 1)) ? WIDTH : $clog2(WARM + 1);
   localparam logic [PHW-1:0] RUN_LAST = PHW'(LEN - 1);
`ifdef SC_DIV_WARMUP_EN
   localparam logic [PHW-1:0] WARM_LAST = PHW'(WARM - 1);
`endif

   state_t           state_q, state_d;
   logic [IDW-1:0]   rrPtr_q, rrPtr_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [PHW-1:0]   phase_q, phase_d;
   logic [WIDTH:0]   ones_q, ones_d;
   logic [IDW-1:0]   rspId_q, rspId_d;
   logic [WIDTH-1:0] rspQuot_q, rspQuot_d;
   logic             rspErr_q, rspErr_d;

   logic             grantFound;
   logic [IDW-1:0]   grantIdx;
   logic             handshake;
   logic [WIDTH-1:0] selDividend;
   logic [WIDTH-1:0] selDivisor;
   logic             aBit;
   logic             bBit;
   logic             qBit;
   logic             coreEn;
   logic [WIDTH:0]   onesInc;
   logic [WIDTH-1:0] quotSat;

   // Round-robin pick: first valid requester at or after the pointer
   always_comb begin
      int cand;
      grantFound = 1'b0;
      grantIdx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(rrPtr_q) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!grantFound && req_valid[cand[IDW-1:0]]) begin
            grantFound = 1'b1;
            grantIdx   = cand[IDW-1:0];
         end
      end
   end

   assign handshake   = (state_q == ST_IDLE) && grantFound;
   assign selDividend = req_dividend[grantIdx*WIDTH +: WIDTH];
   assign selDivisor  = req_divisor[grantIdx*WIDTH +: WIDTH];

   // Ready is suppressed while reset is held so all outputs read zero at once
   assign req_ready = (rst_n && handshake) ? (NREQ'(1) << grantIdx) : '0;

   assign aBit    = (rand_a < dividend_q);
   assign bBit    = (rand_b < divisor_q);
   assign coreEn  = ((state_q == ST_RUN) || (state_q == ST_WARM)) && (divisor_q != '0);
   assign onesInc = ones_q + (WIDTH + 1)'(qBit);
   assign quotSat = onesInc[WIDTH] ? '1 : onesInc[WIDTH-1:0];

   sc_div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (handshake),
      .en_i    (coreEn),
      .inc_i   (aBit),
      .bBit_i  (bBit),
      .randQ_i (rand_q),
      .qBit_o  (qBit)
   );

   // Scheduler FSM: capture a job, run the stream, then hold the result
   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      phase_d    = phase_q;
      ones_d     = ones_q;
      rspId_d    = rspId_q;
      rspQuot_d  = rspQuot_q;
      rspErr_d   = rspErr_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               dividend_d = selDividend;
               divisor_d  = selDivisor;
               rspId_d    = grantIdx;
               rrPtr_d    = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
               phase_d    = '0;
               ones_d     = '0;
`ifdef SC_DIV_WARMUP_EN
               state_d    = ST_WARM;
`else
               state_d    = ST_RUN;
`endif
            end
         end
`ifdef SC_DIV_WARMUP_EN
         ST_WARM: begin
            if (divisor_q == '0) begin
               state_d   = ST_RESP;
               rspQuot_d = '1;
               rspErr_d  = 1'b1;
            end else if (phase_q == WARM_LAST) begin
               state_d = ST_RUN;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
`endif
         ST_RUN: begin
            if (divisor_q == '0) begin
               state_d   = ST_RESP;
               rspQuot_d = '1;
               rspErr_d  = 1'b1;
            end else begin
               ones_d = onesInc;
               if (phase_q == RUN_LAST) begin
                  state_d   = ST_RESP;
                  rspQuot_d = quotSat;
                  rspErr_d  = 1'b0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any job in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rrPtr_q    <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         phase_q    <= '0;
         ones_q     <= '0;
         rspId_q    <= '0;
         rspQuot_q  <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         phase_q    <= phase_d;
         ones_q     <= ones_d;
         rspId_q    <= rspId_d;
         rspQuot_q  <= rspQuot_d;
         rspErr_q   <= rspErr_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_id    = rspId_q;
   assign rsp_quot  = rspQuot_q;
   assign rsp_err   = rspErr_q;

endmodule
